// File: rtl/pixel_pkg.sv
// Shared widths, FSM encodings and helpers for the pixel threshold engine.
// Imported by the engine top and its binarisation datapath.
package pixel_pkg;

  localparam int ADDR_W       = 14;
  localparam int DATA_W       = 32;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;
  localparam int BRIGHT_CNT_W = 17;
  localparam int CNT_W        = ADDR_W + 1;
  localparam int BE_W         = DATA_W / 8;

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1 << ADDR_W);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD   = 3'd1;
  localparam state_t ST_WT   = 3'd2;
  localparam state_t ST_WR   = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  // A request larger than the RAM would revisit words already binarised.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
    return (n > MAX_WORDS) ? MAX_WORDS : n;
  endfunction

endpackage

// File: rtl/pixel_binarize_word.sv
// Combinational 4-lane pixel compare against a threshold, plus a count of
// the lanes that came out bright.
module pixel_binarize_word
  import pixel_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [PIX_W-1:0]  thr,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        bright
);

  always_comb begin
    result = '0;
    bright = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (word[i*PIX_W +: PIX_W] >= thr) begin
        result[i*PIX_W +: PIX_W] = '1;
        bright                   = bright + 3'd1;
      end
    end
  end

endmodule

// File: rtl/pixel_threshold_engine.sv
// In-place binarisation of a word range of the shared pixel RAM through its
// second port: read, threshold each packed pixel, write back, count bright.
//
// state   | meaning
// IDLE    | waiting for start; one armed cycle after an accepted start
// RD      | read issued for cur_addr
// WT      | read data valid, result word and bright count registered
// WR      | result written back to cur_addr, address advances
// DONE    | sweep finished, done pulses
module pixel_threshold_engine
  import pixel_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        word_count,
  input  logic [PIX_W-1:0]        threshold,
  output logic                    busy,
  output logic                    done,
  output logic [BRIGHT_CNT_W-1:0] bright_count,
  output logic [ADDR_W-1:0]       address2,
  output logic                    chipselect2,
  output logic                    write2,
  output logic [DATA_W-1:0]       writedata2,
  output logic [BE_W-1:0]         byteenable2,
  output logic                    clken2,
  input  logic [DATA_W-1:0]       readdata2
);

  state_t            state;
  logic              armed;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic [PIX_W-1:0]  thr;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] bin_word;
  logic [2:0]        bin_bright;

  pixel_binarize_word u_binarize (
    .word   (readdata2),
    .thr    (thr),
    .result (bin_word),
    .bright (bin_bright)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      cur_addr     <= '0;
      remaining    <= '0;
      thr          <= '0;
      result       <= '0;
      bright_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The armed cycle decouples input sampling from the first RAM access.
          if (armed) begin
            armed <= 1'b0;
            state <= (remaining == '0) ? ST_DONE : ST_RD;
          end else if (start) begin
            armed        <= 1'b1;
            cur_addr     <= base_addr;
            remaining    <= clamp_count(word_count);
            thr          <= threshold;
            bright_count <= '0;
          end
        end
        ST_RD: state <= ST_WT;
        ST_WT: begin
          result       <= bin_word;
          bright_count <= bright_count + BRIGHT_CNT_W'(bin_bright);
          state        <= ST_WR;
        end
        ST_WR: begin
          cur_addr  <= cur_addr + ADDR_W'(1);
          remaining <= remaining - CNT_W'(1);
          state     <= (remaining == CNT_W'(1)) ? ST_DONE : ST_RD;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = armed || (state == ST_RD) || (state == ST_WT) || (state == ST_WR);
  assign done = (state == ST_DONE);

  // Gating with reset keeps an interrupted sweep from committing its last word.
  assign chipselect2 = !reset && ((state == ST_RD) || (state == ST_WR));
  assign write2      = !reset && (state == ST_WR);
  assign address2    = cur_addr;
  assign writedata2  = result;
  assign byteenable2 = '1;
  assign clken2      = 1'b1;

endmodule
